bist_fail_logger: RTL and testbench

Downstream stage of the BIST comparator: consumes per-address compare results (`a_eq_b` plus the compared data) during a March pass. It counts miscompares, buffers the first failing entries (address, expected, actual) in a small FIFO for the controller or debug port to drain, and reports a final pass/fail verdict when the test sequence ends.

---
 rtl/bist_fail_logger_pkg.sv | 19 +
 rtl/bist_fail_logger_fifo.sv | 61 ++++++
 rtl/bist_fail_logger.sv | 146 ++++++++++++++
 tb/tb_bist_fail_logger.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bist_fail_logger_pkg.sv
// Shared types for the BIST fail logger: run-state enum and the fail-log entry payload.
package bist_pkg;

    localparam int unsigned BIST_ADDR_W = 8;
    localparam int unsigned BIST_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_log_state_e;

    typedef struct packed {
        logic [BIST_ADDR_W-1:0] addr;
        logic [BIST_DATA_W-1:0] exp;
        logic [BIST_DATA_W-1:0] act;
    } bist_fail_entry_t;

endpackage

// File: rtl/bist_fail_logger_fifo.sv
// DEPTH-entry synchronous FIFO of fail-log entries; pointers carry an extra wrap bit.
module bist_fail_fifo
    import bist_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  bist_fail_entry_t din,
    output bist_fail_entry_t dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = AW + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    bist_fail_entry_t mem_q [DEPTH];

    // Full when indices match but wrap bits differ; a full FIFO still accepts a push alongside a pop.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    // Head reads as zero while empty so the log outputs never expose stale or unwritten storage.
    assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/bist_fail_logger.sv
// BIST fail logger: counts miscompares, logs the first failing entries, reports pass/fail at test end.
// Optional fail-bit accumulator enabled by defining BIST_FAIL_DIAG_EN.
module bist_fail_logger
    import bist_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cmp_valid,
    input  logic              cmp_eq,
    input  logic [ADDR_W-1:0] cmp_addr,
    input  logic [DATA_W-1:0] cmp_exp,
    input  logic [DATA_W-1:0] cmp_act,
    input  logic              test_end,
    input  logic              log_ready,
    output logic              log_valid,
    output logic [ADDR_W-1:0] log_addr,
    output logic [DATA_W-1:0] log_exp,
    output logic [DATA_W-1:0] log_act,
    output logic [CNT_W-1:0]  err_count,
    output logic              overflow,
    output logic [DATA_W-1:0] fail_bits,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    bist_log_state_e  state_q, state_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             overflow_q, overflow_d;
    logic             pass_q, pass_d;
    logic             clr, fail_ev;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    bist_fail_entry_t entry_in, entry_out;

    // Next-state and status update; a start in RUN wins over any compare or test_end that cycle.
    always_comb begin
        state_d     = state_q;
        err_count_d = err_count_q;
        overflow_d  = overflow_q;
        pass_d      = pass_q;
        clr         = 1'b0;
        fail_ev     = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    clr     = 1'b1;
                end
            end
            RUN: begin
                if (start) begin
                    clr = 1'b1;
                end else begin
                    fail_ev = cmp_valid && !cmp_eq;
                    if (test_end) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        fifo_pop  = !fifo_empty && log_ready;
        fifo_push = fail_ev && (!fifo_full || fifo_pop);

        if (clr) begin
            err_count_d = '0;
            overflow_d  = 1'b0;
            pass_d      = 1'b0;
        end else if (fail_ev) begin
            if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
            if (!fifo_push) overflow_d = 1'b1;
        end

        // The verdict uses the count including any fail in the test_end cycle.
        if (state_q == RUN && state_d == DONE) pass_d = (err_count_d == '0);

        entry_in.addr = BIST_ADDR_W'(cmp_addr);
        entry_in.exp  = BIST_DATA_W'(cmp_exp);
        entry_in.act  = BIST_DATA_W'(cmp_act);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            err_count_q <= '0;
            overflow_q  <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_count_q <= err_count_d;
            overflow_q  <= overflow_d;
            pass_q      <= pass_d;
        end
    end

    bist_fail_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (entry_in),
        .dout  (entry_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef BIST_FAIL_DIAG_EN
    logic [DATA_W-1:0] fail_bits_q, fail_bits_d;

    // Accumulates every failing bit position, including entries the log had to drop.
    always_comb begin
        fail_bits_d = fail_bits_q;
        if (clr)          fail_bits_d = '0;
        else if (fail_ev) fail_bits_d = fail_bits_q | (cmp_exp ^ cmp_act);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fail_bits_q <= '0;
        else        fail_bits_q <= fail_bits_d;
    end

    assign fail_bits = fail_bits_q;
`else
    assign fail_bits = '0;
`endif

    assign log_valid = !fifo_empty;
    assign log_addr  = ADDR_W'(entry_out.addr);
    assign log_exp   = DATA_W'(entry_out.exp);
    assign log_act   = DATA_W'(entry_out.act);
    assign err_count = err_count_q;
    assign overflow  = overflow_q;
    assign pass      = pass_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_bist_fail_logger.sv
// Directed self-checking bench for bist_fail_logger with hand-computed expectations.
module tb_bist_fail_logger;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, cmp_valid, cmp_eq, test_end, log_ready;
    logic [7:0]  cmp_addr, cmp_exp, cmp_act;
    logic        log_valid, overflow, busy, done, pass;
    logic [7:0]  log_addr, log_exp, log_act, fail_bits;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

`ifdef BIST_FAIL_DIAG_EN
    localparam logic [7:0] FB_EXP_41 = 8'h41;
`else
    localparam logic [7:0] FB_EXP_41 = 8'h00;
`endif

    always #5 clk = ~clk;

    bist_fail_logger #(
        .ADDR_W (8), .DATA_W (8), .DEPTH (4), .CNT_W (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cmp_valid (cmp_valid),
        .cmp_eq    (cmp_eq),
        .cmp_addr  (cmp_addr),
        .cmp_exp   (cmp_exp),
        .cmp_act   (cmp_act),
        .test_end  (test_end),
        .log_ready (log_ready),
        .log_valid (log_valid),
        .log_addr  (log_addr),
        .log_exp   (log_exp),
        .log_act   (log_act),
        .err_count (err_count),
        .overflow  (overflow),
        .fail_bits (fail_bits),
        .busy      (busy),
        .done      (done),
        .pass      (pass)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it; inputs set afterwards land on the next edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_cmp(input logic [7:0] a, input logic [7:0] e, input logic [7:0] r);
        cmp_valid = 1'b1;
        cmp_eq    = (e == r);
        cmp_addr  = a;
        cmp_exp   = e;
        cmp_act   = r;
        cyc();
        cmp_valid = 1'b0;
    endtask

    task automatic do_end();
        test_end = 1'b1;
        cyc();
        test_end = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] a);
        chk({tag, "_valid"}, 32'(log_valid), 32'd1);
        chk({tag, "_addr"}, 32'(log_addr), 32'(a));
        log_ready = 1'b1;
        cyc();
        log_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cmp_valid = 1'b0; cmp_eq = 1'b0; test_end = 1'b0;
        log_ready = 1'b0; cmp_addr = '0; cmp_exp = '0; cmp_act = '0;
        repeat (2) cyc();
        chk("rst_log_valid", 32'(log_valid), 32'd0);
        chk("rst_log_addr", 32'(log_addr), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_status", 32'({busy, done, pass, overflow}), 32'd0);
        chk("rst_fail_bits", 32'(fail_bits), 32'd0);
        rst_n = 1'b1;
        cyc();

        // All-pass run.
        do_start();
        chk("p_busy", 32'({busy, done}), 32'b10);
        for (int i = 0; i < 10; i++) do_cmp(8'(i), 8'h5A, 8'h5A);
        do_end();
        chk("p_status", 32'({busy, done, pass}), 32'b011);
        chk("p_err", 32'(err_count), 32'd0);
        chk("p_log_valid", 32'(log_valid), 32'd0);

        // Two fails, drained in order.
        do_start();
        chk("f_pass_cleared", 32'(pass), 32'd0);
        do_cmp(8'h03, 8'hAA, 8'hAB);
        chk("f_err1", 32'(err_count), 32'd1);
        chk("f_head_addr", 32'(log_addr), 32'h03);
        chk("f_head_data", 32'({log_exp, log_act}), 32'hAAAB);
        do_cmp(8'h04, 8'h11, 8'h11);
        do_cmp(8'h07, 8'h55, 8'h15);
        cyc();
        chk("f_head_stable", 32'(log_addr), 32'h03);
        do_end();
        chk("f_err2", 32'(err_count), 32'd2);
        chk("f_status", 32'({done, pass}), 32'b10);
        chk("f_fail_bits", 32'(fail_bits), 32'(FB_EXP_41));
        pop_expect("f_pop0", 8'h03);
        chk("f_head2_data", 32'({log_exp, log_act}), 32'h5515);
        pop_expect("f_pop1", 8'h07);
        chk("f_empty", 32'(log_valid), 32'd0);

        // Overflow: six fails into a four-deep log.
        do_start();
        for (int i = 0; i < 4; i++) do_cmp(8'(8'h10 + i), 8'hF0, 8'h0F);
        chk("o_no_ovf_yet", 32'(overflow), 32'd0);
        for (int i = 4; i < 6; i++) do_cmp(8'(8'h10 + i), 8'hF0, 8'h0F);
        chk("o_err6", 32'(err_count), 32'd6);
        chk("o_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) pop_expect("o_pop", 8'(8'h10 + i));
        chk("o_drained", 32'(log_valid), 32'd0);

        // Full FIFO with a fail coincident with a pop: accepted, no overflow.
        do_start();
        chk("c_ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) do_cmp(8'(8'h20 + i), 8'h00, 8'h01);
        log_ready = 1'b1;
        do_cmp(8'h24, 8'h00, 8'h01);
        log_ready = 1'b0;
        chk("c_ovf", 32'(overflow), 32'd0);
        chk("c_err5", 32'(err_count), 32'd5);
        for (int i = 1; i < 5; i++) pop_expect("c_pop", 8'(8'h20 + i));
        chk("c_drained", 32'(log_valid), 32'd0);

        // Fail in the test_end cycle, then fails ignored in DONE.
        do_start();
        test_end = 1'b1;
        do_cmp(8'h30, 8'h0F, 8'h0E);
        test_end = 1'b0;
        chk("e_status", 32'({busy, done, pass}), 32'b010);
        chk("e_err", 32'(err_count), 32'd1);
        do_cmp(8'h31, 8'h0F, 8'h00);
        chk("e_done_ignored", 32'(err_count), 32'd1);

        // Restart mid-run; the compare in the start cycle is discarded.
        do_start();
        for (int i = 0; i < 3; i++) do_cmp(8'(8'h40 + i), 8'hFF, 8'h00);
        chk("r_err3", 32'(err_count), 32'd3);
        start = 1'b1;
        do_cmp(8'h50, 8'hFF, 8'h00);
        start = 1'b0;
        chk("r_err0", 32'(err_count), 32'd0);
        chk("r_empty_busy", 32'({log_valid, busy}), 32'b01);
        chk("r_fail_bits", 32'(fail_bits), 32'd0);
        do_cmp(8'h51, 8'hFF, 8'h00);
        chk("r_first_cmp", 32'(err_count), 32'd1);

        // Asynchronous reset between edges.
        rst_n = 1'b0;
        #2;
        chk("a_err", 32'(err_count), 32'd0);
        chk("a_status", 32'({log_valid, busy, done, pass, overflow}), 32'd0);
        chk("a_head", 32'(log_addr), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Fails in IDLE are ignored.
        do_cmp(8'h60, 8'h12, 8'h34);
        chk("i_err", 32'(err_count), 32'd0);
        chk("i_log", 32'({log_valid, busy}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
